// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the cache/SDRAM arbiter: FSM state codes,
// owner codes and the beat-counter width helper.
package cache_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_XFER = 2'b10,
    ST_GAP  = 2'b11
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } arb_owner_t;

  // Width of a counter that indexes BURST_LEN beats (never below 1 bit).
  function automatic int cnt_width(input int burst_len);
    return (burst_len > 2) ? $clog2(burst_len) : 1;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_arb_beat_counter.sv
// Beat counter for one line burst: clears outside a transfer, counts
// accepted beats and flags the final beat of the line.
module arb_beat_counter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = cnt_width(BURST_LEN)
)(
  input  logic clk,
  input  logic n_RST,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_last = (r_cnt == LAST_CNT);

  // Count beats; the last beat wraps to zero so the next burst starts clean.
  always_ff @(posedge clk or negedge n_RST) begin
    if (!n_RST)      r_cnt <= '0;
    else if (i_clr)  r_cnt <= '0;
    else if (i_inc)  r_cnt <= o_last ? '0 : r_cnt + 1'b1;
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the SDRAM controller port between I-cache fills and D-cache
// fills/write-backs. One line burst of BURST_LEN beats per grant, followed
// by a single GAP cycle so the served requester can drop its request.
// Optional feature macro: ARB_ROUND_ROBIN_EN (tie goes to the requester not
// served last); when undefined, D-cache has fixed priority over I-cache.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 4
)(
  input  logic              clk,
  input  logic              n_RST,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_busy,
  output logic              i_rvalid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_wnext,
  output logic              d_busy,
  output logic              d_rvalid,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic              mem_wnext,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = cnt_width(BURST_LEN);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BURST_LEN - 1);

  arb_state_t        r_state, w_state_nxt;
  arb_owner_t        r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;

  logic              w_any_req;
  logic              w_grant;
  logic              w_d_win;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_own_i, w_own_d;
  logic              w_beat, w_last;

  assign w_any_req = i_req | d_req;
  assign w_grant   = (r_state == ST_IDLE) & w_any_req;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = D-cache held the last grant; reset value means I was served last.
  logic r_last_d;

  // On a tie the requester not served last wins; a lone request always wins.
  assign w_d_win = d_req & (~i_req | ~r_last_d);

  // Remember who won each grant so contended bursts alternate.
  always_ff @(posedge clk or negedge n_RST) begin
    if (!n_RST)       r_last_d <= 1'b0;
    else if (w_grant) r_last_d <= w_d_win;
  end
`else
  // Fixed priority: any D request beats a simultaneous I request.
  assign w_d_win = d_req;
`endif

  assign w_sel_addr = w_d_win ? d_addr : i_addr;
  assign w_own_i    = (r_owner == OWN_I);
  assign w_own_d    = (r_owner == OWN_D);

  // A beat is whichever strobe matches the latched direction, only in XFER.
  assign w_beat    = (r_state == ST_XFER) & (r_we ? mem_wnext : mem_rvalid);
  assign mem_wdata = d_wdata;

  arb_beat_counter #(
    .BURST_LEN (BURST_LEN),
    .CNT_W     (CNT_W)
  ) u_beat_cnt (
    .clk    (clk),
    .n_RST  (n_RST),
    .i_clr  (r_state != ST_XFER),
    .i_inc  (w_beat),
    .o_last (w_last)
  );

  // Latch owner, direction and line-aligned address when a grant is made;
  // later changes on the request inputs are ignored until the next grant.
  always_ff @(posedge clk or negedge n_RST) begin
    if (!n_RST) begin
      r_owner <= OWN_NONE;
      r_we    <= 1'b0;
      r_addr  <= '0;
    end else if (w_grant) begin
      r_owner <= w_d_win ? OWN_D : OWN_I;
      r_we    <= w_d_win & d_we;
      r_addr  <= w_sel_addr & LINE_MASK;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge n_RST) begin
    if (!n_RST) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state plus all port outputs; everything idles at zero by default.
  always_comb begin
    w_state_nxt = r_state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    i_busy      = 1'b0;
    i_rvalid    = 1'b0;
    i_done      = 1'b0;
    d_busy      = 1'b0;
    d_rvalid    = 1'b0;
    d_wnext     = 1'b0;
    d_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        mem_req  = 1'b1;
        mem_we   = r_we;
        mem_addr = r_addr;
        i_busy   = w_own_i;
        d_busy   = w_own_d;
        if (mem_ack) w_state_nxt = ST_XFER;
      end
      ST_XFER: begin
        mem_we   = r_we;
        mem_addr = r_addr;
        i_busy   = w_own_i;
        d_busy   = w_own_d;
        i_rvalid = w_own_i & mem_rvalid;
        d_rvalid = w_own_d & ~r_we & mem_rvalid;
        d_wnext  = w_own_d & r_we & mem_wnext;
        i_done   = w_own_i & w_beat & w_last;
        d_done   = w_own_d & w_beat & w_last;
        if (w_beat & w_last) w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        i_busy      = w_own_i;
        d_busy      = w_own_d;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: a table of single-burst
// vectors plus hand-written sequences for stray strobes, mid-burst request
// drop, mid-burst reset and contended arbitration. Expected grants, read
// beat owners and write words go into queues when stimulus is driven and a
// negedge monitor pops and compares them as the DUT responds.
module tb_cache_mem_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          n_RST = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_busy, i_rvalid, i_done;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_wnext, d_busy, d_rvalid, d_done;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic          mem_wnext = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .n_RST(n_RST),
    .i_req(i_req), .i_addr(i_addr), .i_busy(i_busy), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wnext(d_wnext),
    .d_busy(d_busy), .d_rvalid(d_rvalid), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_wnext(mem_wnext), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_d; bit we; logic [AW-1:0] addr; } grant_t;
  typedef struct { bit is_d; bit we; logic [AW-1:0] addr; logic [AW-1:0] exp_addr; } vec_t;

  grant_t        g_q[$];
  bit            own_q[$];
  logic [DW-1:0] w_q[$];
  grant_t        g_cur;
  bit            m_own;
  logic [DW-1:0] m_w;
  int            beats = 0;
  int            n_done = 0;
  logic          prev_req = 1'b0;
  int            n_vec = 0;
  int            n_bad = 0;
  vec_t          tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares grants, beat steering and done pulses on the falling edge.
  always @(negedge clk) begin
    if (!n_RST) begin
      prev_req = 1'b0;
      beats    = 0;
    end else begin
      if (mem_req && !prev_req) begin
        if (g_q.size() == 0) chk("grant_unexpected", 32'(mem_req), 32'd0);
        else begin
          g_cur = g_q.pop_front();
          chk("grant_addr", 32'(mem_addr), 32'(g_cur.addr));
          chk("grant_we", 32'(mem_we), 32'(g_cur.we));
          chk("grant_busy", 32'({i_busy, d_busy}), g_cur.is_d ? 32'd1 : 32'd2);
          beats = 0;
        end
      end
      prev_req = mem_req;
      if (i_rvalid || d_rvalid) begin
        if (own_q.size() == 0) chk("stray_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
        else begin
          m_own = own_q.pop_front();
          chk("rvalid_owner", 32'({i_rvalid, d_rvalid}), m_own ? 32'd1 : 32'd2);
          beats++;
        end
      end
      if (d_wnext) begin
        if (w_q.size() == 0) chk("stray_wnext", 32'(d_wnext), 32'd0);
        else begin
          m_w = w_q.pop_front();
          chk("wnext_data", 32'(mem_wdata), 32'(m_w));
          beats++;
        end
      end
      if (i_done || d_done) begin
        chk("done_owner", 32'({i_done, d_done}), g_cur.is_d ? 32'd1 : 32'd2);
        chk("done_beat", 32'(beats), 32'(BL));
        beats = 0;
        n_done++;
      end
    end
  end

  task automatic set_req(input bit is_d, input bit v);
    if (is_d) d_req = v; else i_req = v;
  endtask

  // Plays the SDRAM controller for one burst owned by is_d. Optional hooks:
  // reset after beat rst_at, drop I request after beat drop_at, stray
  // strobes in REQ/GAP, and re-raise the request after the GAP.
  task automatic serve(input bit is_d, input bit we, input int rst_at,
                       input int drop_at, input bit stray, input bit rearm);
    int n = 0;
    int d0;
    logic [AW-1:0] sav_a;
    logic sav_we;
    do begin @(posedge clk); #1; n++; end while (!mem_req && n < 30);
    chk("req_latency", 32'(n), 32'd1);
    if (!mem_req) return;
    if (is_d) begin sav_a = d_addr; sav_we = d_we; d_addr = ~d_addr; d_we = ~d_we; end
    else begin sav_a = i_addr; sav_we = 1'b0; i_addr = ~i_addr; end
    if (stray) begin
      mem_rvalid = 1'b1; @(posedge clk); #1; mem_rvalid = 1'b0;
      chk("req_hold", 32'(mem_req), 32'd1);
    end
    d0 = n_done;
    mem_ack = 1'b1; @(posedge clk); #1; mem_ack = 1'b0;
    for (int k = 0; k < BL; k++) begin
      if (k == 1) begin @(posedge clk); #1; end
      if (we) begin
        d_wdata = 16'(16'h1111 * (k + 1)); w_q.push_back(d_wdata); mem_wnext = 1'b1;
      end else begin
        mem_rdata = 16'(16'hA000 + k); own_q.push_back(is_d); mem_rvalid = 1'b1;
      end
      @(posedge clk); #1;
      mem_wnext = 1'b0; mem_rvalid = 1'b0;
      if (k + 1 == drop_at) set_req(is_d, 1'b0);
      if (k + 1 == rst_at) begin
        n_RST = 1'b0; #1;
        chk("rst_outputs", 32'({mem_req, mem_we, i_busy, d_busy, i_rvalid, d_rvalid,
                                i_done, d_done, d_wnext}), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        i_req = 1'b0; d_req = 1'b0;
        if (is_d) begin d_addr = sav_a; d_we = sav_we; end else i_addr = sav_a;
        repeat (2) @(posedge clk);
        #1; n_RST = 1'b1;
        return;
      end
    end
    chk("done_pulse", 32'(n_done - d0), 32'd1);
    chk("gap_busy", 32'({i_busy, d_busy}), is_d ? 32'd1 : 32'd2);
    if (is_d) begin d_addr = sav_a; d_we = sav_we; end else i_addr = sav_a;
    set_req(is_d, 1'b0);
    if (stray) mem_rvalid = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("idle_busy", 32'({i_busy, d_busy}), 32'd0);
    if (rearm) set_req(is_d, 1'b1);
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 24'h001237, 24'h001234};
    tbl[1] = '{1'b1, 1'b1, 24'h00ABC0, 24'h00ABC0};
    tbl[2] = '{1'b1, 1'b0, 24'hFFFFFF, 24'hFFFFFC};
    tbl[3] = '{1'b0, 1'b0, 24'h000003, 24'h000000};
    tbl[4] = '{1'b1, 1'b1, 24'h123456, 24'h123454};

    // Reset state
    #2;
    chk("reset_outputs", 32'({mem_req, mem_we, i_busy, d_busy, i_rvalid, d_rvalid,
                              i_done, d_done, d_wnext}), 32'd0);
    chk("reset_addr", 32'(mem_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1; n_RST = 1'b1;

    // Stray controller strobes while idle
    mem_ack = 1'b1; @(posedge clk); #1; mem_ack = 1'b0;
    chk("idle_ack_ignored", 32'({mem_req, i_busy, d_busy}), 32'd0);
    mem_rvalid = 1'b1; #1;
    chk("idle_rvalid_ignored", 32'({i_rvalid, d_rvalid}), 32'd0);
    @(posedge clk); #1; mem_rvalid = 1'b0;

    // Table of lone bursts
    for (int v = 0; v < 5; v++) begin
      g_q.push_back('{tbl[v].is_d, tbl[v].we, tbl[v].exp_addr});
      if (tbl[v].is_d) begin d_addr = tbl[v].addr; d_we = tbl[v].we; d_req = 1'b1; end
      else begin i_addr = tbl[v].addr; i_req = 1'b1; end
      serve(tbl[v].is_d, tbl[v].we, 0, 0, 1'b0, 1'b0);
    end

    // I fill with stray beats in REQ/GAP and i_req dropped after beat 2
    i_addr = 24'h000041;
    g_q.push_back('{1'b0, 1'b0, 24'h000040});
    i_req = 1'b1;
    serve(1'b0, 1'b0, 0, 2, 1'b1, 1'b0);

    // D fill reset after beat 2, then a clean I fill
    d_addr = 24'h000302; d_we = 1'b0;
    g_q.push_back('{1'b1, 1'b0, 24'h000300});
    d_req = 1'b1;
    serve(1'b1, 1'b0, 2, 0, 1'b0, 1'b0);
    i_addr = 24'h001237;
    g_q.push_back('{1'b0, 1'b0, 24'h001234});
    i_req = 1'b1;
    serve(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

    // Same-cycle tie: D first, I straight after the GAP
    i_addr = 24'h000100; d_addr = 24'h000208; d_we = 1'b0;
    g_q.push_back('{1'b1, 1'b0, 24'h000208});
    g_q.push_back('{1'b0, 1'b0, 24'h000100});
    i_req = 1'b1; d_req = 1'b1;
    serve(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    serve(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

`ifdef ARB_ROUND_ROBIN_EN
    // Contended back-to-back bursts alternate D, I, D, I
    g_q.push_back('{1'b1, 1'b0, 24'h000208});
    g_q.push_back('{1'b0, 1'b0, 24'h000100});
    g_q.push_back('{1'b1, 1'b0, 24'h000208});
    g_q.push_back('{1'b0, 1'b0, 24'h000100});
    g_q.push_back('{1'b1, 1'b0, 24'h000208});
    i_req = 1'b1; d_req = 1'b1;
    serve(1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
    serve(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    serve(1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
    serve(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    serve(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("final_idle", 32'({mem_req, i_busy, d_busy}), 32'd0);
    chk("queues_drained", 32'(g_q.size() + own_q.size() + w_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

endmodule
